layer_header_sequencer: RTL and testbench
=========================================

Name: layer_header_sequencer

Overview:
- Per-frame walker for the layer header register bank. On each frame_start it steps pipe_layer through layers 0..NUM_LAYERS-1 and captures each layer's 128-bit header.
- Disabled layers are skipped. Each enabled header is presented to the next pipeline stage over a valid/ready handshake.
- Sits between the layer register bank's pipeline read port and the pipe_3 layer fetch stage. frame_done marks the end of each walk.

Parameters:
- NUM_LAYERS, 32, number of layers walked per frame (2..32).
- LAYER_W, 5, width of layer index; 2**LAYER_W >= NUM_LAYERS.
- HDR_W, 128, header width (8 x 16-bit registers).
- ENABLE_BIT, 0, bit of header register 0 (hdr bit ENABLE_BIT) that marks a layer enabled.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous, active-low reset.
- frame_start  in  1  single-cycle pulse that begins a walk.
- pipe_layer  out  LAYER_W  layer address to the register bank's pipeline read port.
- pipe_allRegisters  in  HDR_W  header read data; valid 1 cycle after pipe_layer is driven.
- hdr_valid  out  1  header presented downstream.
- hdr_ready  in  1  downstream accepts the header.
- hdr_data  out  HDR_W  captured header.
- hdr_layer  out  LAYER_W  layer index of hdr_data.
- busy  out  1  a walk is in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse at the end of a walk.
- frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - state=IDLE, idx=0, pipe_layer=0.
  - hdr_valid=0, hdr_data=0, hdr_layer=0.
  - busy=0, frame_done=0, frame_overrun=0.
- Reset mid-walk abandons the walk immediately. No frame_done is produced.
- All outputs are registered. pipe_layer always equals idx.
- State machine:
  - IDLE: on frame_start, idx<=0 and go to ISSUE. Otherwise stay.
  - ISSUE: pipe_layer=idx. Always go to CAPTURE, covering the 1-cycle bank read latency.
  - CAPTURE: hdr_data<=pipe_allRegisters and hdr_layer<=idx.
    - If pipe_allRegisters[ENABLE_BIT]=1: hdr_valid<=1 and go to PRESENT.
    - Else if idx==NUM_LAYERS-1: go to DONE.
    - Else: idx<=idx+1 and go to ISSUE.
  - PRESENT: hold hdr_valid=1, with hdr_data and hdr_layer stable, until hdr_valid&&hdr_ready.
    - On handshake: hdr_valid<=0.
    - Then, if idx==NUM_LAYERS-1, go to DONE. Else idx<=idx+1 and go to ISSUE.
  - DONE: frame_done=1 for exactly this cycle, then IDLE. idx wraps to 0.
- Handshake rules:
  - hdr_valid never drops without a handshake.
  - hdr_ready with hdr_valid=0 is ignored.
  - Transfer occurs on any cycle where both are high.
- Throughput: 3 cycles per enabled layer with hdr_ready held high; 2 cycles per disabled layer.
- Latency:
  - frame_start sampled at cycle 0 gives ISSUE at cycle 1.
  - The earliest hdr_valid is cycle 3.
- Boundary conditions:
  - frame_start while busy, including in DONE: ignored, and frame_overrun pulses for 1 cycle. The walk continues unaffected.
  - frame_start in the same cycle frame_done is asserted: treated as overrun and ignored.
  - No layers enabled: no hdr_valid at all, but frame_done is still produced.
  - The last layer is visited exactly once; there is no wrap to layer 0 within a walk.
  - The header is sampled once, in CAPTURE. Bank writes to that layer during PRESENT do not alter hdr_data.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release -> all outputs 0 and busy=0. A frame_start pulse at cycle 0 gives pipe_layer=0 at cycle 1 and busy=1.
- All 32 layers enabled, hdr_ready held at 1, frame_start at cycle 0 -> hdr_valid at cycles 3,6,...,96 with hdr_layer 0..31 in order. frame_done at cycle 97, busy=0 at cycle 98.
- All layers disabled, frame_start at cycle 0 -> hdr_valid never asserts and frame_done pulses at cycle 65.
- Only layers 5 and 31 enabled, header word0=0x0001 (layer 5) and 0x8001 (layer 31) -> two transfers: hdr_layer=5 then hdr_layer=31, each with hdr_data[15:0] matching its word0. Then frame_done.
- Backpressure: layer 0 enabled, hdr_ready=0 for 10 cycles then 1 -> hdr_valid and hdr_data stay stable for 11 cycles. Exactly one transfer occurs, and pipe_layer holds 0 throughout.
- frame_start pulsed at cycle 10 during a walk -> frame_overrun=1 at cycle 11 only, and the walk completes normally. Separately, rst_n=0 at cycle 20 mid-walk -> IDLE next cycle and no frame_done.

Source files
------------

// File: rtl/layer_header_sequencer.sv
// rtl/layer_header_sequencer.sv - per-frame walker that fetches and presents enabled layer headers
//
// Ports:
//   clk               pipeline clock
//   rst_n             synchronous active-low reset
//   frame_start       single-cycle pulse that begins a walk
//   pipe_layer        layer address to the register bank pipeline read port
//   pipe_allRegisters header read data, valid one cycle after pipe_layer
//   hdr_valid         header presented downstream
//   hdr_ready         downstream accepts the header
//   hdr_data          captured header
//   hdr_layer         layer index of hdr_data
//   busy              a walk is in progress
//   frame_done        one-cycle pulse at the end of a walk
//   frame_overrun     one-cycle pulse when frame_start arrives while busy

module layer_header_sequencer #(
    parameter int NUM_LAYERS = 32,
    parameter int LAYER_W    = 5,
    parameter int HDR_W      = 128,
    parameter int ENABLE_BIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    output logic [LAYER_W-1:0] pipe_layer,
    input  logic [HDR_W-1:0]   pipe_allRegisters,
    output logic               hdr_valid,
    input  logic               hdr_ready,
    output logic [HDR_W-1:0]   hdr_data,
    output logic [LAYER_W-1:0] hdr_layer,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PRESENT,
        DONE
    } state_t;

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [LAYER_W-1:0] idx;
    logic [LAYER_W-1:0] idx_nxt;
    logic               hdr_valid_nxt;
    logic [HDR_W-1:0]   hdr_data_nxt;
    logic [LAYER_W-1:0] hdr_layer_nxt;

    // idx is itself a register, so the read address is a registered output.
    assign pipe_layer = idx;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        hdr_valid_nxt = hdr_valid;
        hdr_data_nxt  = hdr_data;
        hdr_layer_nxt = hdr_layer;

        case (state)
            IDLE: begin
                if (frame_start) begin
                    idx_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end

            // Address is already on pipe_layer; this cycle absorbs the bank read latency.
            ISSUE: begin
                state_nxt = CAPTURE;
            end

            // The only point where the header is sampled, so later bank writes
            // to this layer cannot disturb a header waiting in PRESENT.
            CAPTURE: begin
                hdr_data_nxt  = pipe_allRegisters;
                hdr_layer_nxt = idx;
                if (pipe_allRegisters[ENABLE_BIT]) begin
                    hdr_valid_nxt = 1'b1;
                    state_nxt     = PRESENT;
                end else if (idx == LAST_LAYER) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + LAYER_W'(1);
                    state_nxt = ISSUE;
                end
            end

            // hdr_valid is always high here, so hdr_ready alone completes the transfer.
            PRESENT: begin
                if (hdr_ready) begin
                    hdr_valid_nxt = 1'b0;
                    if (idx == LAST_LAYER) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + LAYER_W'(1);
                        state_nxt = ISSUE;
                    end
                end
            end

            DONE: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end

            default: begin
                idx_nxt       = '0;
                hdr_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            hdr_valid     <= 1'b0;
            hdr_data      <= '0;
            hdr_layer     <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            hdr_valid     <= hdr_valid_nxt;
            hdr_data      <= hdr_data_nxt;
            hdr_layer     <= hdr_layer_nxt;
            // Status flags follow the state being entered so they line up with it.
            busy          <= (state_nxt != IDLE);
            frame_done    <= (state_nxt == DONE);
            // DONE counts as busy, so a start coinciding with frame_done is an overrun.
            frame_overrun <= frame_start && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_layer_header_sequencer.sv
// tb/tb_layer_header_sequencer.sv - self-checking bench for layer_header_sequencer

module tb_layer_header_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_start;
    logic [4:0]   pipe_layer;
    logic [127:0] pipe_allRegisters;
    logic         hdr_valid;
    logic         hdr_ready;
    logic [127:0] hdr_data;
    logic [4:0]   hdr_layer;
    logic         busy;
    logic         frame_done;
    logic         frame_overrun;

    logic [127:0] bank [32];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] mask;
        int          exp_xfers;
        int          exp_first;
        int          exp_last;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    layer_header_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_start       (frame_start),
        .pipe_layer        (pipe_layer),
        .pipe_allRegisters (pipe_allRegisters),
        .hdr_valid         (hdr_valid),
        .hdr_ready         (hdr_ready),
        .hdr_data          (hdr_data),
        .hdr_layer         (hdr_layer),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_overrun     (frame_overrun)
    );

    always #5 clk = ~clk;

    // Register bank model with one cycle of read latency.
    always @(posedge clk) pipe_allRegisters <= bank[pipe_layer];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] hdr_pat(input int l, input bit en);
        logic [15:0] w0;
        logic [7:0]  b;
        w0 = en ? 16'h0001 : 16'h0000;
        if (en && l == 31) w0 = 16'h8001;
        b = 8'(l) ^ 8'hC3;
        return {{14{b}}, w0};
    endfunction

    task automatic load_bank(input logic [31:0] mask);
        for (int l = 0; l < 32; l++) bank[l] = hdr_pat(l, mask[l]);
    endtask

    // Cycle at which layer l is presented: start at cycle 0, ISSUE at 1,
    // 3 cycles per enabled and 2 per disabled earlier layer, valid 2 after ISSUE.
    function automatic int exp_cycle(input logic [31:0] m, input int l);
        int t;
        t = 1;
        for (int k = 0; k < l; k++) t += m[k] ? 3 : 2;
        return t + 2;
    endfunction

    task automatic run_walk(input logic [31:0] mask, output int n_xfer, output int first_v,
                            output int last_v, output int done_c);
        int exp_q [$];
        int l;
        for (int k = 0; k < 32; k++) if (mask[k]) exp_q.push_back(k);
        n_xfer = 0; first_v = -1; last_v = -1; done_c = -1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (hdr_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (hdr_valid && hdr_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL extra_xfer: layer %0d at cycle %0d, expected none", hdr_layer, c);
                end else begin
                    l = exp_q.pop_front();
                    check("xfer_layer", 128'(hdr_layer), 128'(l));
                    check("xfer_data", hdr_data, bank[l]);
                    check("xfer_cycle", 128'(c), 128'(exp_cycle(mask, l)));
                end
                n_xfer++;
            end
            if (frame_done) begin
                done_c = c;
                check("busy_in_done", 128'(busy), 128'(1));
                break;
            end
            tick();
        end
        if (done_c < 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no frame_done, expected one");
        end
        tick();
        check("busy_after_done", 128'(busy), 128'(0));
        check("done_pulse_width", 128'(frame_done), 128'(0));
        check("pipe_layer_wrap", 128'(pipe_layer), 128'(0));
    endtask

    initial begin
        int xf, fv, lv, dc, ov_cnt, ov_c, cnt_done, cnt_valid;
        logic [127:0] saved;

        vecs[0] = '{32'hFFFF_FFFF, 32, 3,  96, 97};
        vecs[1] = '{32'h0000_0000, 0,  -1, -1, 65};
        vecs[2] = '{32'h8000_0020, 2,  13, 66, 67};
        vecs[3] = '{32'h0000_0001, 1,  3,  3,  66};
        vecs[4] = '{32'h5555_5555, 16, 3,  78, 81};
        vecs[5] = '{32'h8000_0000, 1,  65, 65, 66};

        rst_n = 1'b0; frame_start = 1'b0; hdr_ready = 1'b0;
        load_bank(32'h0);

        // Reset state
        tick(); tick();
        check("rst_valid", 128'(hdr_valid), 128'(0));
        check("rst_data", hdr_data, 128'(0));
        check("rst_layer", 128'(hdr_layer), 128'(0));
        check("rst_pipe_layer", 128'(pipe_layer), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(frame_done), 128'(0));
        check("rst_overrun", 128'(frame_overrun), 128'(0));
        rst_n = 1'b1;
        tick();
        check("idle_busy", 128'(busy), 128'(0));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("c1_pipe_layer", 128'(pipe_layer), 128'(0));
        check("c1_busy", 128'(busy), 128'(1));
        check("c1_valid", 128'(hdr_valid), 128'(0));
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

        // Table-driven walks with hdr_ready held high
        hdr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load_bank(vecs[i].mask);
            run_walk(vecs[i].mask, xf, fv, lv, dc);
            check($sformatf("v%0d_xfers", i), 128'(xf), 128'(vecs[i].exp_xfers));
            check($sformatf("v%0d_first", i), 128'(fv), 128'(vecs[i].exp_first));
            check($sformatf("v%0d_last", i), 128'(lv), 128'(vecs[i].exp_last));
            check($sformatf("v%0d_done", i), 128'(dc), 128'(vecs[i].exp_done));
        end

        // Backpressure on layer 0, with a bank write while the header waits
        load_bank(32'h1);
        hdr_ready = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick(); tick();
        saved = bank[0];
        bank[0] = ~bank[0];
        xf = 0;
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) hdr_ready = 1'b1;
            check("bp_valid", 128'(hdr_valid), 128'(1));
            check("bp_data", hdr_data, saved);
            check("bp_layer", 128'(hdr_layer), 128'(0));
            check("bp_pipe_layer", 128'(pipe_layer), 128'(0));
            if (hdr_valid && hdr_ready) xf++;
            tick();
        end
        check("bp_valid_drop", 128'(hdr_valid), 128'(0));
        dc = -1;
        for (int c = 14; c <= 200; c++) begin
            if (hdr_valid && hdr_ready) xf++;
            if (frame_done) begin dc = c; break; end
            tick();
        end
        check("bp_xfers", 128'(xf), 128'(1));
        check("bp_done", 128'(dc), 128'(76));
        tick();
        bank[0] = saved;

        // Overrun mid-walk and in the frame_done cycle
        load_bank(32'hFFFF_FFFF);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        xf = 0; ov_cnt = 0; ov_c = -1; dc = -1;
        for (int c = 1; c <= 200; c++) begin
            if (frame_overrun) begin ov_cnt++; ov_c = c; end
            if (hdr_valid && hdr_ready) xf++;
            frame_start = (c == 10) || frame_done;
            if (frame_done) begin dc = c; break; end
            tick();
        end
        check("ov_count", 128'(ov_cnt), 128'(1));
        check("ov_cycle", 128'(ov_c), 128'(11));
        check("ov_xfers", 128'(xf), 128'(32));
        check("ov_done", 128'(dc), 128'(97));
        tick();
        frame_start = 1'b0;
        check("ov_in_done", 128'(frame_overrun), 128'(1));
        check("ov_in_done_busy", 128'(busy), 128'(0));
        tick();
        check("ov_not_restarted", 128'(busy), 128'(0));
        check("ov_pulse_width", 128'(frame_overrun), 128'(0));

        // Reset mid-walk
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rst_n = 1'b0;
        tick();
        check("mrst_busy", 128'(busy), 128'(0));
        check("mrst_valid", 128'(hdr_valid), 128'(0));
        check("mrst_pipe_layer", 128'(pipe_layer), 128'(0));
        rst_n = 1'b1;
        cnt_done = 0; cnt_valid = 0;
        for (int c = 0; c < 120; c++) begin
            if (frame_done) cnt_done++;
            if (hdr_valid) cnt_valid++;
            tick();
        end
        check("mrst_no_done", 128'(cnt_done), 128'(0));
        check("mrst_no_valid", 128'(cnt_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
